obf_key_loader: RTL and testbench

- Sequential key-provisioning block for the logic-locked c432 netlist, which exposes 12 key inputs s_0..s_11.
- Receives the key serially from the secure key store over a valid/ready bit handshake, then checks even parity.
- Commits the key atomically to a held register that drives s_0..s_11.
- Repeated failed loads lock the block until reset, so the locked circuit never sees a partial or corrupted key.

---
 rtl/obf_key_pkg.sv | 15 +
 rtl/obf_key_loader_if.sv | 23 ++
 rtl/obf_key_shifter.sv | 48 ++++
 rtl/obf_key_loader.sv | 109 ++++++++++
 tb/tb_obf_key_loader.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obf_key_pkg.sv
// Shared types and sizing for the c432 key loader.
package obf_key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam int KEY_W_DEF    = 12;
  localparam int MAX_FAIL_DEF = 3;
  localparam int FAIL_W       = $clog2(MAX_FAIL_DEF + 1);

endpackage

// File: rtl/obf_key_loader_if.sv
// Serial bit handshake between the secure key store and the loader.
interface obf_key_loader_if;

  logic load_start;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output load_start,
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  load_start,
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );

endinterface

// File: rtl/obf_key_shifter.sv
// Shadow register, bit counter and running parity for one key frame.
// The parity bit is folded into the running parity but never stored.
module obf_key_shifter
  import obf_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic             last_bit,
  output logic             parity_ok
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] PARITY_POS = CNT_W'(KEY_W);

  logic [KEY_W-1:0] shadow_q;
  logic [CNT_W-1:0] count_q;
  logic             parity_q;

  // Frame start wins over a same-cycle shift; key bits land at shadow[count].
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shadow_q <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      count_q  <= '0;
      parity_q <= 1'b0;
    end else if (shift_en) begin
      parity_q <= parity_q ^ bit_in;
      if (count_q != PARITY_POS) begin
        shadow_q[count_q] <= bit_in;
        count_q           <= count_q + 1'b1;
      end
    end
  end

  assign shadow    = shadow_q;
  assign last_bit  = shift_en && (count_q == PARITY_POS);
  assign parity_ok = ~parity_q;

endmodule

// File: rtl/obf_key_loader.sv
// Key provisioning for the logic-locked c432: serial load, even-parity
// check, atomic commit, and lockout after repeated parity failures.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  obf_key_loader_if.slave  bus,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             locked,
  output logic             busy
);

  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q;
  logic              key_valid_q;
  logic              key_err_q;
  logic [FAIL_W-1:0] fail_q;
  logic [FAIL_W-1:0] fail_inc;
  logic              hit_lim;

  logic              sh_load, sh_clear, sh_shift;
  logic [KEY_W-1:0]  shadow;
  logic              last_bit, parity_ok;

  assign fail_inc = (fail_q == FAIL_LIM) ? fail_q : fail_q + 1'b1;
  assign hit_lim  = (fail_inc == FAIL_LIM);

  assign sh_load  = ((state_q == IDLE) || (state_q == SHIFT)) && bus.load_start;
  assign sh_shift = (state_q == SHIFT) && bus.bit_valid && !bus.load_start;
  assign sh_clear = (state_q == LOCK);

  obf_key_shifter #(.KEY_W(KEY_W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .clear     (sh_clear),
    .shift_en  (sh_shift),
    .bit_in    (bus.bit_in),
    .shadow    (shadow),
    .last_bit  (last_bit),
    .parity_ok (parity_ok)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a restart keeps SHIFT and drops any same-cycle bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.load_start) state_d = SHIFT;
      SHIFT: if (!bus.load_start && last_bit) state_d = CHECK;
      CHECK: begin
        if (parity_ok)    state_d = IDLE;
        else if (hit_lim) state_d = LOCK;
        else              state_d = IDLE;
      end
      LOCK:  state_d = LOCK;
      default: state_d = IDLE;
    endcase
  end

  // Commit register, error pulse and fail counter; a passing commit beats key_clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      fail_q      <= '0;
    end else begin
      key_err_q <= 1'b0;
      if (state_q == CHECK && parity_ok) begin
        key_q       <= shadow;
        key_valid_q <= 1'b1;
        fail_q      <= '0;
      end else if (state_q == CHECK) begin
        key_err_q <= 1'b1;
        fail_q    <= fail_inc;
        if (hit_lim || key_clear) begin
          key_q       <= '0;
          key_valid_q <= 1'b0;
        end
      end else if (state_q == LOCK || key_clear) begin
        key_q       <= '0;
        key_valid_q <= 1'b0;
      end
    end
  end

  assign bus.bit_ready = (state_q == SHIFT);
  assign busy          = (state_q == SHIFT) || (state_q == CHECK);
  assign locked        = (state_q == LOCK);
  assign key_out       = key_q;
  assign key_valid     = key_valid_q;
  assign key_err       = key_err_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// Self-checking bench for obf_key_loader: a table of frames plus
// hand-written lockout, restart, clear and reset sequences.
module tb_obf_key_loader;
  import obf_key_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_clear;
  logic [11:0] key_out;
  logic        key_valid, key_err, locked, busy;

  obf_key_loader_if bus ();

  obf_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_err   (key_err),
    .locked    (locked),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] key;
    logic        valid;
    logic        err;
    logic        lock;
  } exp_t;

  typedef struct {
    logic [11:0] key;
    logic        pbit;
    logic        gaps;
    logic [11:0] exp_key;
    logic        exp_err;
  } vec_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [11:0] m_key;
  logic        m_valid;
  logic        m_locked;
  int          m_fail;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one frame's outcome, pushed to the scoreboard.
  task automatic model_push(input logic [11:0] k, input logic p);
    exp_t e;
    e.err = 1'b0;
    if ((^{k, p}) == 1'b0) begin
      m_key   = k;
      m_valid = 1'b1;
      m_fail  = 0;
    end else begin
      e.err = 1'b1;
      m_fail++;
      if (m_fail == 3) begin
        m_locked = 1'b1;
        m_key    = '0;
        m_valid  = 1'b0;
      end
    end
    e.key   = m_key;
    e.valid = m_valid;
    e.lock  = m_locked;
    sb_q.push_back(e);
  endtask

  task automatic reset_dut(input bit check);
    rst_n = 1'b0;
    tick();
    if (check) begin
      check_output("rst_key_out", key_out, 0);
      check_output("rst_key_valid", key_valid, 0);
      check_output("rst_key_err", key_err, 0);
      check_output("rst_locked", locked, 0);
      check_output("rst_bit_ready", bus.bit_ready, 0);
      check_output("rst_busy", busy, 0);
    end
    rst_n    = 1'b1;
    m_key    = '0;
    m_valid  = 1'b0;
    m_locked = 1'b0;
    m_fail   = 0;
    sb_q.delete();
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    while (!ok && n < 50) begin
      ok = bus.bit_ready;
      tick();
      n++;
    end
    bus.bit_valid = 1'b0;
    if (!ok) check_output("bit_accept_timeout", 0, 1);
  endtask

  task automatic maybe_gap(input logic gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.bit_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  // Sends key bits first..11 then parity, checks the CHECK cycle, pops the scoreboard.
  task automatic apply_stimulus(input logic [11:0] k, input logic p, input logic gaps,
                                input bit start, input bit clr_in_check, input int first,
                                input logic [11:0] hold_key);
    exp_t e;
    if (start) pulse_start();
    for (int i = first; i < 12; i++) begin
      maybe_gap(gaps);
      send_bit(k[i]);
    end
    maybe_gap(gaps);
    send_bit(p);
    check_output("check_busy", busy, 1);
    check_output("check_ready_low", bus.bit_ready, 0);
    check_output("check_key_hold", key_out, hold_key);
    if (clr_in_check) key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    if (sb_q.size() == 0) begin
      check_output("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_output("commit_key_out", key_out, e.key);
      check_output("commit_key_valid", key_valid, e.valid);
      check_output("commit_key_err", key_err, e.err);
      check_output("commit_locked", locked, e.lock);
      check_output("commit_busy", busy, 0);
    end
    tick();
    check_output("err_one_cycle", key_err, 0);
  endtask

  initial begin
    vec_t        vec[17];
    exp_t        e;
    logic [11:0] hold;
    logic        any_ready;

    rst_n          = 1'b0;
    key_clear      = 1'b0;
    bus.load_start = 1'b0;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;

    vec[0]  = '{12'hA5C, 1'b0, 1'b0, 12'hA5C, 1'b0};
    vec[1]  = '{12'h3F0, 1'b0, 1'b1, 12'h3F0, 1'b0};
    vec[2]  = '{12'hA5C, 1'b1, 1'b0, 12'h3F0, 1'b1};
    vec[3]  = '{12'h123, 1'b0, 1'b1, 12'h123, 1'b0};
    vec[4]  = '{12'hFFF, 1'b0, 1'b0, 12'hFFF, 1'b0};
    vec[5]  = '{12'h001, 1'b1, 1'b1, 12'h001, 1'b0};
    vec[6]  = '{12'h001, 1'b0, 1'b0, 12'h001, 1'b1};
    vec[7]  = '{12'h800, 1'b0, 1'b1, 12'h001, 1'b1};
    vec[8]  = '{12'h555, 1'b0, 1'b0, 12'h555, 1'b0};
    vec[9]  = '{12'h7FF, 1'b1, 1'b1, 12'h7FF, 1'b0};
    vec[10] = '{12'h000, 1'b0, 1'b0, 12'h000, 1'b0};
    vec[11] = '{12'h0F0, 1'b0, 1'b1, 12'h0F0, 1'b0};
    vec[12] = '{12'h001, 1'b0, 1'b0, 12'h0F0, 1'b1};
    vec[13] = '{12'h002, 1'b0, 1'b1, 12'h0F0, 1'b1};
    vec[14] = '{12'h555, 1'b0, 1'b0, 12'h555, 1'b0};
    vec[15] = '{12'h004, 1'b0, 1'b1, 12'h555, 1'b1};
    vec[16] = '{12'h008, 1'b0, 1'b0, 12'h555, 1'b1};

    tick();
    reset_dut(1'b1);

    // Bits offered in IDLE are not accepted.
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    repeat (3) tick();
    check_output("idle_ready_low", bus.bit_ready, 0);
    check_output("idle_busy_low", busy, 0);
    bus.bit_valid = 1'b0;

    // Table of frames, including two-bad/good/two-bad without lockout.
    for (int i = 0; i < 17; i++) begin
      hold    = m_key;
      e.key   = vec[i].exp_key;
      e.valid = 1'b1;
      e.err   = vec[i].exp_err;
      e.lock  = 1'b0;
      sb_q.push_back(e);
      m_key   = vec[i].exp_key;
      m_valid = 1'b1;
      apply_stimulus(vec[i].key, vec[i].pbit, vec[i].gaps, 1'b1, 1'b0, 0, hold);
    end

    // key_clear zeroises a committed key on the next edge.
    hold = m_key;
    model_push(12'hA5C, 1'b0);
    apply_stimulus(12'hA5C, 1'b0, 1'b0, 1'b1, 1'b0, 0, hold);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check_output("clear_key_out", key_out, 0);
    check_output("clear_key_valid", key_valid, 0);
    m_key   = '0;
    m_valid = 1'b0;

    // key_clear coinciding with a passing CHECK loses to the commit.
    hold = m_key;
    model_push(12'h3F0, 1'b0);
    apply_stimulus(12'h3F0, 1'b0, 1'b0, 1'b1, 1'b1, 0, hold);

    // key_clear mid-frame clears key_out but the frame still completes.
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    key_clear = 1'b1;
    send_bit(1'b1);
    key_clear = 1'b0;
    check_output("clear_shift_key_out", key_out, 0);
    check_output("clear_shift_busy", busy, 1);
    m_key   = '0;
    m_valid = 1'b0;
    model_push(12'h5FF, 1'b0);
    apply_stimulus(12'h5FF, 1'b0, 1'b0, 1'b0, 1'b0, 5, 12'h000);

    // Restart: aborted bits and a same-cycle dropped bit leave no trace.
    reset_dut(1'b0);
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.load_start = 1'b1;
    bus.bit_valid  = 1'b1;
    bus.bit_in     = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    check_output("restart_busy", busy, 1);
    model_push(12'h123, 1'b0);
    apply_stimulus(12'h123, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h000);

    // Reset mid-SHIFT discards the frame; a fresh frame then loads.
    pulse_start();
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    reset_dut(1'b1);
    model_push(12'h3F0, 1'b0);
    apply_stimulus(12'h3F0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000);

    // Lockout after three consecutive bad frames.
    for (int i = 0; i < 3; i++) begin
      hold = m_key;
      model_push(12'hA5C, 1'b1);
      apply_stimulus(12'hA5C, 1'b1, 1'b0, 1'b1, 1'b0, 0, hold);
    end
    check_output("lock_key_out", key_out, 0);
    pulse_start();
    any_ready     = 1'b0;
    bus.bit_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      any_ready = any_ready | bus.bit_ready;
      tick();
    end
    bus.bit_valid = 1'b0;
    check_output("lock_ready_never", any_ready, 0);
    check_output("lock_still_locked", locked, 1);
    check_output("lock_key_zero", key_out, 0);
    check_output("lock_valid_zero", key_valid, 0);
    reset_dut(1'b0);
    check_output("unlock_after_reset", locked, 0);
    model_push(12'hA5C, 1'b0);
    apply_stimulus(12'hA5C, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
